// File: rtl/ahb_to_apb_bridge_if.sv
`default_nettype none
// ============================================================================
//  Module      : ahb_to_apb_bridge_if
//  Description : Bus bundle for the AHB-Lite to APB bridge. Carries the AHB
//                slave-side signals and the APB master-side signals.
//                  slave  modport : the bridge view
//                  master modport : the AHB manager plus APB completer view
//                Optional feature macro AHB2APB_PSLVERR_EN adds pslverr_i.
//  Revision    : 1.0 - initial release
// ============================================================================
interface ahb_to_apb_bridge_if #(
    parameter int ADDR_WIDTH   = 32,
    parameter int HBURST_WIDTH = 3,
    parameter int HPROT_WIDTH  = 4,
    parameter int DATA_WIDTH   = 32
);
    // AHB side
    logic [ADDR_WIDTH-1:0]     haddr_i;
    logic [HBURST_WIDTH-1:0]   hburst_i;
    logic                      hmastlock_i;
    logic                      hsel_i;
    logic [HPROT_WIDTH-1:0]    hprot_i;
    logic [2:0]                hsize_i;
    logic                      hnonsec_i;
    logic                      hexcl_i;
    logic                      hmaster_i;
    logic [1:0]                htrans_i;
    logic [DATA_WIDTH-1:0]     hwdata_i;
    logic [DATA_WIDTH/8-1:0]   hwstrb_i;
    logic                      hwrite_i;
    logic [DATA_WIDTH-1:0]     hrdata_o;
    logic                      hready_o;
    logic                      hreadyout_o;
    logic                      hresp_o;
    logic                      hexokay_o;

    // APB side
    logic [ADDR_WIDTH-1:0]     paddr_o;
    logic                      psel_o;
    logic                      penable_o;
    logic                      pwrite_o;
    logic [DATA_WIDTH-1:0]     pwdata_o;
    logic [DATA_WIDTH/8-1:0]   pstrb_o;
    logic [DATA_WIDTH-1:0]     prdata_i;
    logic                      pready_i;
`ifdef AHB2APB_PSLVERR_EN
    logic                      pslverr_i;
`endif

    modport slave (
        input  haddr_i, hburst_i, hmastlock_i, hsel_i, hprot_i, hsize_i,
               hnonsec_i, hexcl_i, hmaster_i, htrans_i, hwdata_i, hwstrb_i,
               hwrite_i, prdata_i, pready_i,
`ifdef AHB2APB_PSLVERR_EN
        input  pslverr_i,
`endif
        output hrdata_o, hready_o, hreadyout_o, hresp_o, hexokay_o,
               paddr_o, psel_o, penable_o, pwrite_o, pwdata_o, pstrb_o
    );

    modport master (
        output haddr_i, hburst_i, hmastlock_i, hsel_i, hprot_i, hsize_i,
               hnonsec_i, hexcl_i, hmaster_i, htrans_i, hwdata_i, hwstrb_i,
               hwrite_i, prdata_i, pready_i,
`ifdef AHB2APB_PSLVERR_EN
        output pslverr_i,
`endif
        input  hrdata_o, hready_o, hreadyout_o, hresp_o, hexokay_o,
               paddr_o, psel_o, penable_o, pwrite_o, pwdata_o, pstrb_o
    );
endinterface
`default_nettype wire

// File: rtl/ahb_to_apb_bridge.sv
`default_nettype none
// ============================================================================
//  Module      : ahb_to_apb_bridge
//  Description : AHB-Lite slave to APB master bridge, single clock domain.
//                Every accepted AHB NONSEQ/SEQ beat becomes one APB
//                SETUP+ACCESS transfer; hreadyout_o stretches the AHB data
//                phase until the APB completer signals pready_i.
//  Ports       : clk   - clock, rising edge
//                reset - asynchronous, active-low reset
//                bus   - ahb_to_apb_bridge_if.slave (AHB slave + APB master)
//  Options     : AHB2APB_PSLVERR_EN - adds pslverr_i; an APB slave error is
//                returned as a two-cycle AHB ERROR response.
//  Revision    : 1.0 - initial release
// ============================================================================
module ahb_to_apb_bridge #(
    parameter int ADDR_WIDTH   = 32,
    parameter int HBURST_WIDTH = 3,
    parameter int HPROT_WIDTH  = 4,
    parameter int DATA_WIDTH   = 32
) (
    input  logic                 clk,
    input  logic                 reset,
    ahb_to_apb_bridge_if.slave   bus
);

    localparam int c_STRB_WIDTH = DATA_WIDTH / 8;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_WDATA  = 3'd1,
        S_SETUP  = 3'd2,
        S_ACCESS = 3'd3,
        S_ERR1   = 3'd4,
        S_ERR2   = 3'd5
    } state_t;

    state_t                   r_state;
    logic [ADDR_WIDTH-1:0]    r_paddr;
    logic                     r_pwrite;
    logic [DATA_WIDTH-1:0]    r_pwdata;
    logic [c_STRB_WIDTH-1:0]  r_pstrb;
    logic                     r_psel;
    logic                     r_penable;
    logic [DATA_WIDTH-1:0]    r_hrdata;
`ifdef AHB2APB_PSLVERR_EN
    logic                     r_hresp;
`endif

    logic                     w_pslverr;
    logic                     w_hreadyout;
    logic                     w_acc;
    logic                     w_rd_done;

`ifdef AHB2APB_PSLVERR_EN
    assign w_pslverr = bus.pslverr_i;
`else
    assign w_pslverr = 1'b0;
`endif

    // The AHB data phase is released in IDLE, on a clean APB completion, and
    // in the second cycle of an error response. An erroring completion holds
    // hready low for one cycle so the master can react to hresp first.
    always_comb begin
        w_hreadyout = 1'b0;
        case (r_state)
            S_IDLE:   w_hreadyout = 1'b1;
            S_ACCESS: w_hreadyout = bus.pready_i & ~w_pslverr;
            S_ERR2:   w_hreadyout = 1'b1;
            default:  w_hreadyout = 1'b0;
        endcase
    end

    assign w_acc     = bus.hsel_i & w_hreadyout & bus.htrans_i[1];
    assign w_rd_done = (r_state == S_ACCESS) & bus.pready_i & ~r_pwrite;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state   <= S_IDLE;
            r_paddr   <= '0;
            r_pwrite  <= 1'b0;
            r_pwdata  <= '0;
            r_pstrb   <= '0;
            r_psel    <= 1'b0;
            r_penable <= 1'b0;
            r_hrdata  <= '0;
`ifdef AHB2APB_PSLVERR_EN
            r_hresp   <= 1'b0;
`endif
        end else begin
            if (w_rd_done) begin
                r_hrdata <= bus.prdata_i;
            end

            if (w_hreadyout) begin
                // Bus free this cycle: take a new address phase or go idle.
                // Reads go straight to SETUP; writes spend one cycle in
                // WDATA because hwdata_i only appears in the data phase.
                r_penable <= 1'b0;
`ifdef AHB2APB_PSLVERR_EN
                r_hresp   <= 1'b0;
`endif
                if (w_acc) begin
                    r_paddr  <= bus.haddr_i;
                    r_pwrite <= bus.hwrite_i;
                    r_psel   <= ~bus.hwrite_i;
                    r_state  <= bus.hwrite_i ? S_WDATA : S_SETUP;
                end else begin
                    r_psel   <= 1'b0;
                    r_state  <= S_IDLE;
                end
            end else begin
                case (r_state)
                    S_WDATA: begin
                        r_pwdata <= bus.hwdata_i;
                        r_pstrb  <= bus.hwstrb_i;
                        r_psel   <= 1'b1;
                        r_state  <= S_SETUP;
                    end
                    S_SETUP: begin
                        r_penable <= 1'b1;
                        r_state   <= S_ACCESS;
                    end
                    S_ACCESS: begin
                        // hready is low here, so pready_i=1 can only mean
                        // the completer flagged an error.
                        if (bus.pready_i) begin
                            r_psel    <= 1'b0;
                            r_penable <= 1'b0;
                            r_state   <= S_ERR1;
`ifdef AHB2APB_PSLVERR_EN
                            r_hresp   <= 1'b1;
`endif
                        end
                    end
                    S_ERR1: begin
                        r_state <= S_ERR2;
                    end
                    default: begin
                        r_psel    <= 1'b0;
                        r_penable <= 1'b0;
                        r_state   <= S_IDLE;
                    end
                endcase
            end
        end
    end

    assign bus.hreadyout_o = w_hreadyout;
    assign bus.hready_o    = w_hreadyout;
    assign bus.hrdata_o    = w_rd_done ? bus.prdata_i : r_hrdata;
`ifdef AHB2APB_PSLVERR_EN
    assign bus.hresp_o     = r_hresp;
`else
    assign bus.hresp_o     = 1'b0;
`endif
    assign bus.hexokay_o   = 1'b0;
    assign bus.paddr_o     = r_paddr;
    assign bus.psel_o      = r_psel;
    assign bus.penable_o   = r_penable;
    assign bus.pwrite_o    = r_pwrite;
    assign bus.pwdata_o    = r_pwdata;
    assign bus.pstrb_o     = r_pstrb;

    // Attributes the bridge deliberately ignores.
    logic [HBURST_WIDTH-1:0] w_unused_hburst;
    logic [HPROT_WIDTH-1:0]  w_unused_hprot;
    logic                    w_unused;
    assign w_unused_hburst = bus.hburst_i;
    assign w_unused_hprot  = bus.hprot_i;
    assign w_unused = ^{w_unused_hburst, w_unused_hprot, bus.hmastlock_i,
                        bus.hsize_i, bus.hnonsec_i, bus.hexcl_i,
                        bus.hmaster_i, bus.htrans_i[0]};

endmodule
`default_nettype wire

// File: tb/tb_ahb_to_apb_bridge.sv
`default_nettype none
// ============================================================================
//  Module      : tb_ahb_to_apb_bridge
//  Description : Randomized self-checking bench for ahb_to_apb_bridge. The
//                reference model tracks the one outstanding beat as a set of
//                cycle timestamps (acceptance, ACCESS start, completion) and
//                derives every expected output from them.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_ahb_to_apb_bridge;

    logic clk   = 1'b0;
    logic reset = 1'b0;

    ahb_to_apb_bridge_if #(
        .ADDR_WIDTH(32), .HBURST_WIDTH(3), .HPROT_WIDTH(4), .DATA_WIDTH(32)
    ) bus ();

    ahb_to_apb_bridge #(
        .ADDR_WIDTH(32), .HBURST_WIDTH(3), .HPROT_WIDTH(4), .DATA_WIDTH(32)
    ) u_dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    // Reference model: one beat in flight, described by timestamps.
    bit          m_act      = 1'b0;
    bit          m_wr       = 1'b0;
    bit          m_forced   = 1'b0;
    bit          force_read = 1'b0;
    bit          prev_rdy   = 1'b1;
    logic [31:0] m_addr     = '0;
    logic [31:0] m_wdata    = '0;
    logic [3:0]  m_strb     = '0;
    logic [31:0] m_rdlast   = '0;
    int          m_a        = 0;   // first ACCESS cycle
    int          m_done     = 0;   // completion cycle

    // Address phase currently driven by the bench.
    bit          a_sel   = 1'b0;
    bit          a_write = 1'b0;
    logic [1:0]  a_trans = 2'b00;
    logic [31:0] a_addr  = '0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    task automatic drive_idle();
        a_sel = 1'b0; a_trans = 2'b00; a_write = 1'b0; a_addr = '0;
        bus.hsel_i   = 1'b0;
        bus.htrans_i = 2'b00;
        bus.hwrite_i = 1'b0;
        bus.haddr_i  = '0;
    endtask

    task automatic new_addr_phase();
        int unsigned r;
        r = force_read ? 9 : $urandom_range(0, 9);
        a_addr  = $urandom;
        a_write = force_read ? 1'b0 : 1'($urandom_range(0, 1));
        case (r)
            0:       begin a_sel = 1'b1; a_trans = 2'b00; end
            1:       begin a_sel = 1'b1; a_trans = 2'b01; end
            2:       begin a_sel = 1'b0; a_trans = 2'b10; end
            default: begin a_sel = 1'b1; a_trans = 2'($urandom_range(2, 3)); end
        endcase
        bus.hsel_i      = a_sel;
        bus.htrans_i    = a_trans;
        bus.hwrite_i    = a_write;
        bus.haddr_i     = a_addr;
        bus.hburst_i    = 3'($urandom);
        bus.hprot_i     = 4'($urandom);
        bus.hsize_i     = 3'($urandom);
        bus.hmastlock_i = 1'($urandom);
        bus.hnonsec_i   = 1'($urandom);
        bus.hexcl_i     = 1'($urandom);
        bus.hmaster_i   = 1'($urandom);
    endtask

    task automatic step();
        logic        exp_rdy, exp_psel, exp_pen, done_now;
        logic [31:0] drv_prdata, exp_rd;
        @(negedge clk);
        exp_rdy  = !m_act || (cyc == m_done);
        exp_psel = m_act && (cyc >= m_a - 1);
        exp_pen  = m_act && (cyc >= m_a);
        done_now = m_act && (cyc == m_done);

        // Address phase may only change after hready was high.
        if (prev_rdy) new_addr_phase();
        bus.pready_i = exp_pen ? done_now : 1'($urandom_range(0, 1));
        drv_prdata   = $urandom;
        bus.prdata_i = drv_prdata;
        bus.hwdata_i = (m_act && m_wr) ? m_wdata : 32'($urandom);
        bus.hwstrb_i = (m_act && m_wr) ? m_strb  : 4'($urandom);
        #1;

        chk("hready_o",    64'(bus.hready_o),    64'(exp_rdy));
        chk("hreadyout_o", 64'(bus.hreadyout_o), 64'(exp_rdy));
        chk("psel_o",      64'(bus.psel_o),      64'(exp_psel));
        chk("penable_o",   64'(bus.penable_o),   64'(exp_pen));
        chk("hresp_o",     64'(bus.hresp_o),     64'(0));
        chk("hexokay_o",   64'(bus.hexokay_o),   64'(0));
        if (exp_psel) begin
            chk("paddr_o",  64'(bus.paddr_o),  64'(m_addr));
            chk("pwrite_o", 64'(bus.pwrite_o), 64'(m_wr));
            if (m_wr) begin
                chk("pwdata_o", 64'(bus.pwdata_o), 64'(m_wdata));
                chk("pstrb_o",  64'(bus.pstrb_o),  64'(m_strb));
            end
        end
        exp_rd = (done_now && !m_wr) ? drv_prdata : m_rdlast;
        chk("hrdata_o", 64'(bus.hrdata_o), 64'(exp_rd));
        m_rdlast = exp_rd;

        if (done_now) m_act = 1'b0;
        if (exp_rdy && a_sel && a_trans[1]) begin
            m_act    = 1'b1;
            m_wr     = a_write;
            m_addr   = a_addr;
            m_a      = cyc + (a_write ? 3 : 2);
            m_done   = m_a + (force_read ? 3 : int'($urandom_range(0, 3)));
            m_wdata  = $urandom;
            m_strb   = 4'($urandom);
            m_forced = force_read;
            force_read = 1'b0;
        end
        prev_rdy = exp_rdy;
        cyc++;
    endtask

    task automatic check_reset_state(input string pfx);
        chk({pfx, "_psel"},    64'(bus.psel_o),      64'(0));
        chk({pfx, "_penable"}, 64'(bus.penable_o),   64'(0));
        chk({pfx, "_hready"},  64'(bus.hreadyout_o), 64'(1));
        chk({pfx, "_hresp"},   64'(bus.hresp_o),     64'(0));
        chk({pfx, "_paddr"},   64'(bus.paddr_o),     64'(0));
        chk({pfx, "_pwdata"},  64'(bus.pwdata_o),    64'(0));
        chk({pfx, "_pstrb"},   64'(bus.pstrb_o),     64'(0));
        chk({pfx, "_pwrite"},  64'(bus.pwrite_o),    64'(0));
        chk({pfx, "_hrdata"},  64'(bus.hrdata_o),    64'(0));
    endtask

    initial begin
        int guard;
        drive_idle();
        bus.hburst_i = '0; bus.hprot_i = '0; bus.hsize_i = '0;
        bus.hmastlock_i = 1'b0; bus.hnonsec_i = 1'b0; bus.hexcl_i = 1'b0;
        bus.hmaster_i = 1'b0; bus.hwdata_i = '0; bus.hwstrb_i = '0;
        bus.prdata_i = '0; bus.pready_i = 1'b0;
`ifdef AHB2APB_PSLVERR_EN
        bus.pslverr_i = 1'b0;
`endif
        #1;
        check_reset_state("por");
        @(negedge clk);
        reset = 1'b1;

        for (int i = 0; i < 500; i++) step();

        // Asynchronous reset while a read sits in ACCESS with pready low.
        force_read = 1'b1;
        guard = 0;
        while (!(m_forced && m_act && cyc > m_a) && guard < 60) begin
            step();
            guard++;
        end
        if (guard >= 60) begin
            chk("reset_access_timeout", 64'(0), 64'(1));
        end else begin
            chk("pre_reset_penable", 64'(bus.penable_o), 64'(1));
            #1;
            reset = 1'b0;
            #1;
            check_reset_state("midrst");
        end
        m_act = 1'b0; m_forced = 1'b0; force_read = 1'b0;
        m_rdlast = '0; prev_rdy = 1'b1;
        drive_idle();
        @(negedge clk);
        reset = 1'b1;
        cyc++;

        for (int i = 0; i < 500; i++) step();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
